// File: rtl/arith_seq_pkg.sv
// Shared types for the arithmetic-unit sequencer: state encoding, order selection and defaults.
package arith_seq_pkg;

   localparam int unsigned DEF_WORD_W = 31;
   localparam int unsigned DEF_STEPS  = 30;
   localparam int unsigned DEF_CNT_W  = 5;
   localparam int unsigned ORDER_N    = 6;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADD_SUM,
      S_SUB_NOTA,
      S_SUB_CMP,
      S_SUB_FIX,
      S_MUL_CLRB,
      S_MUL_SUM,
      S_MUL_SHIFT,
      S_DIV_NOTA,
      S_DIV_CMP,
      S_DIV_SHIFT,
      S_DIV_SUM,
      S_AND_OP,
      S_IO_SHIFT,
      S_ANS
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV,
      OP_AND,
      OP_IO
   } op_t;

   // Order vector bit order is {io, and, div, mul, sub, add}; lowest bit wins.
   function automatic op_t pick_order(input logic [ORDER_N-1:0] v);
      if (v[0])      return OP_ADD;
      else if (v[1]) return OP_SUB;
      else if (v[2]) return OP_MUL;
      else if (v[3]) return OP_DIV;
      else if (v[4]) return OP_AND;
      else           return OP_IO;
   endfunction

   function automatic logic multi_order(input logic [ORDER_N-1:0] v);
      return (v & (v - ORDER_N'(1))) != '0;
   endfunction

endpackage

// File: rtl/arith_step_counter.sv
// Iteration / shift counter with clear, increment and a last-step flag against a runtime limit.
module arith_step_counter
   import arith_seq_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             last_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= count + CNT_W'(1);
   end

   // High on the final iteration, i.e. when count has reached limit-1.
   assign last_c = (count == limit - CNT_W'(1));

endmodule

// File: rtl/arith_seq_ctrl.sv
// Encoded local program generator: turns add/sub/mul/div/and/io orders into AU micro-op pulses.
module arith_seq_ctrl
   import arith_seq_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned STEPS  = DEF_STEPS,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear_a_from_pu,
   input  logic             move_b_to_c_from_pu,
   input  logic             move_c_to_b_from_pu,
   input  logic             move_c_to_a_from_pu,
   input  logic             order_add_from_op,
   input  logic             order_sub_from_op,
   input  logic             order_mul_from_op,
   input  logic             order_div_from_op,
   input  logic             order_and_from_op,
   input  logic             order_io_from_io,
   input  logic [CNT_W-1:0] io_shift_count,
   input  logic             io_digit4,
   input  logic             mem_read_sign_from_mem,
   input  logic             carry_out_from_au,
   input  logic             reg_c_msb_from_au,
   input  logic             reg_b_0_from_au,
   output logic             au_answer_to_op,
   output logic             arith_overflow_to_op,
   output logic             order_error_to_op,
   output logic             busy_to_op,
   output logic             do_clear_a_to_au,
   output logic             do_clear_b_to_au,
   output logic             do_clear_c_to_au,
   output logic             do_not_a_to_au,
   output logic             do_not_b_to_au,
   output logic             do_sum_to_au,
   output logic             do_and_to_au,
   output logic             do_set_c_msb_to_au,
   output logic             do_left_shift_b_to_au,
   output logic             do_left_shift_c_to_au,
   output logic             do_left_shift_c_low_to_au,
   output logic             do_right_shift_bc_to_au,
   output logic             do_move_c_to_a_to_au,
   output logic             do_move_c_to_b_to_au,
   output logic             do_move_b_to_c_to_au,
   output logic             reg_a_sign_to_op,
   output logic             reg_b_sign_to_op,
   output logic             reg_b_sign_to_pu,
   output logic             mem_write_sign_to_mem,
   output logic             reg_c_sign_to_io
);

   generate
      if (WORD_W < 2 || STEPS < 1 || STEPS > (2 ** CNT_W) - 1) begin : g_bad_params
         $error("arith_seq_ctrl: illegal WORD_W/STEPS/CNT_W combination");
      end
   endgenerate

   state_t             state;
   op_t                op;
   op_t                sel;
   logic               a_sign;
   logic               b_sign;
   logic               c_sign;
   logic               neg;
   logic               div_last;
   logic               order_error;
   logic [CNT_W-1:0]   io_len;
   logic               io_digit;
   logic [ORDER_N-1:0] orders;
   logic               any_order;
   logic               any_move;
   logic               idle;
   logic               overflow;
   logic               cnt_clr;
   logic               cnt_inc;
   logic [CNT_W-1:0]   cnt_limit;
   logic               last;

   assign orders    = {order_io_from_io, order_and_from_op, order_div_from_op,
                       order_mul_from_op, order_sub_from_op, order_add_from_op};
   assign any_order = |orders;
   assign any_move  = move_b_to_c_from_pu | move_c_to_b_from_pu | move_c_to_a_from_pu;
   assign sel       = pick_order(orders);
   assign idle      = (state == S_IDLE);

   // Overflow aborts add before the sum and div after the trial subtraction.
   assign overflow  = !clear_a_from_pu && carry_out_from_au &&
                      (state == S_ADD_SUM || state == S_DIV_CMP);

   assign cnt_clr   = clear_a_from_pu || idle || state == S_ANS || overflow;
   assign cnt_inc   = (state == S_MUL_SHIFT) || (state == S_DIV_SHIFT) || (state == S_IO_SHIFT);
   assign cnt_limit = (op == OP_IO) ? io_len : CNT_W'(STEPS);

   arith_step_counter #(.CNT_W(CNT_W)) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .limit  (cnt_limit),
      .last_c (last)
   );

   // Sequencer state, captured order context and sign registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         op          <= OP_ADD;
         a_sign      <= 1'b0;
         b_sign      <= 1'b0;
         c_sign      <= 1'b0;
         neg         <= 1'b0;
         div_last    <= 1'b0;
         order_error <= 1'b0;
         io_len      <= '0;
         io_digit    <= 1'b0;
      end else begin
         order_error <= 1'b0;
         if (clear_a_from_pu) begin
            state  <= S_IDLE;
            a_sign <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (any_order) begin
                     op          <= sel;
                     a_sign      <= mem_read_sign_from_mem;
                     neg         <= 1'b0;
                     div_last    <= 1'b0;
                     io_len      <= io_shift_count;
                     io_digit    <= io_digit4;
                     order_error <= multi_order(orders);
                     case (sel)
                        OP_ADD:  state <= S_ADD_SUM;
                        OP_SUB:  state <= S_SUB_NOTA;
                        OP_MUL:  state <= S_MUL_CLRB;
                        OP_DIV:  state <= S_DIV_NOTA;
                        OP_AND:  state <= S_AND_OP;
                        default: state <= (io_shift_count == '0) ? S_ANS : S_IO_SHIFT;
                     endcase
                  end else begin
                     if (move_b_to_c_from_pu) c_sign <= b_sign;
                     if (move_c_to_b_from_pu) b_sign <= c_sign;
                     if (move_c_to_a_from_pu) a_sign <= c_sign;
                  end
               end
               S_ADD_SUM:   state <= carry_out_from_au ? S_IDLE : S_ANS;
               S_SUB_NOTA:  state <= S_SUB_CMP;
               S_SUB_CMP: begin
                  if (carry_out_from_au) begin
                     state <= S_ANS;
                  end else begin
                     state <= S_SUB_FIX;
                     neg   <= 1'b1;
                  end
               end
               S_SUB_FIX:   state <= S_ANS;
               S_MUL_CLRB:  state <= S_MUL_SUM;
               S_MUL_SUM:   state <= S_MUL_SHIFT;
               S_MUL_SHIFT: state <= last ? S_ANS : S_MUL_SUM;
               S_DIV_NOTA:  state <= S_DIV_CMP;
               S_DIV_CMP:   state <= carry_out_from_au ? S_IDLE : S_DIV_SHIFT;
               S_DIV_SHIFT: begin
                  div_last <= last;
                  state    <= S_DIV_SUM;
               end
               S_DIV_SUM:   state <= div_last ? S_ANS : S_DIV_SHIFT;
               S_AND_OP:    state <= S_ANS;
               S_IO_SHIFT:  state <= last ? S_ANS : S_IO_SHIFT;
               S_ANS: begin
                  state <= S_IDLE;
                  case (op)
                     OP_ADD:  c_sign <= b_sign;
                     OP_SUB:  c_sign <= b_sign ^ neg;
                     OP_MUL:  c_sign <= a_sign ^ b_sign;
                     OP_DIV:  b_sign <= a_sign ^ b_sign;
                     OP_AND:  b_sign <= a_sign & b_sign;
                     default: ;
                  endcase
               end
               default:     state <= S_IDLE;
            endcase
            // Anything arriving while an order is in flight is dropped and flagged.
            if (!idle && (any_order || any_move))
               order_error <= 1'b1;
         end
      end
   end

   // Micro-op decode: depends on the current state and same-cycle AU status.
   always_comb begin
      do_clear_a_to_au          = clear_a_from_pu;
      do_clear_b_to_au          = 1'b0;
      do_clear_c_to_au          = 1'b0;
      do_not_a_to_au            = 1'b0;
      do_not_b_to_au            = 1'b0;
      do_sum_to_au              = 1'b0;
      do_and_to_au              = 1'b0;
      do_set_c_msb_to_au        = 1'b0;
      do_left_shift_b_to_au     = 1'b0;
      do_left_shift_c_to_au     = 1'b0;
      do_left_shift_c_low_to_au = 1'b0;
      do_right_shift_bc_to_au   = 1'b0;
      do_move_c_to_a_to_au      = 1'b0;
      do_move_c_to_b_to_au      = 1'b0;
      do_move_b_to_c_to_au      = 1'b0;
      if (!clear_a_from_pu) begin
         case (state)
            S_IDLE: begin
               do_move_b_to_c_to_au = move_b_to_c_from_pu;
               do_move_c_to_b_to_au = move_c_to_b_from_pu;
               do_move_c_to_a_to_au = move_c_to_a_from_pu;
            end
            S_ADD_SUM:   do_sum_to_au = !carry_out_from_au;
            S_SUB_NOTA:  do_not_a_to_au = 1'b1;
            S_SUB_CMP: begin
               if (carry_out_from_au) begin
                  do_sum_to_au = 1'b1;
               end else begin
                  do_not_a_to_au = 1'b1;
                  do_not_b_to_au = 1'b1;
               end
            end
            S_SUB_FIX:   do_sum_to_au = 1'b1;
            S_MUL_CLRB:  do_clear_b_to_au = 1'b1;
            S_MUL_SUM:   do_sum_to_au = reg_c_msb_from_au;
            S_MUL_SHIFT: do_right_shift_bc_to_au = 1'b1;
            S_DIV_NOTA:  do_not_a_to_au = 1'b1;
            S_DIV_SHIFT: begin
               do_left_shift_b_to_au     = 1'b1;
               do_left_shift_c_to_au     = 1'b1;
               do_left_shift_c_low_to_au = 1'b1;
            end
            S_DIV_SUM: begin
               do_sum_to_au       = carry_out_from_au ^ reg_b_0_from_au;
               do_set_c_msb_to_au = carry_out_from_au ^ reg_b_0_from_au;
            end
            S_AND_OP:    do_and_to_au = 1'b1;
            S_IO_SHIFT: begin
               do_left_shift_c_to_au     = 1'b1;
               do_left_shift_c_low_to_au = io_digit;
            end
            S_ANS: begin
               case (op)
                  OP_ADD, OP_SUB, OP_MUL: do_move_b_to_c_to_au = 1'b1;
                  OP_DIV, OP_AND:         do_move_c_to_b_to_au = 1'b1;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign au_answer_to_op       = (state == S_ANS) && !clear_a_from_pu;
   assign arith_overflow_to_op  = overflow;
   assign order_error_to_op     = order_error;
   assign busy_to_op            = !idle;
   assign reg_a_sign_to_op      = a_sign;
   assign reg_b_sign_to_op      = b_sign;
   assign reg_b_sign_to_pu      = b_sign;
   assign mem_write_sign_to_mem = c_sign;
   assign reg_c_sign_to_io      = c_sign;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Self-checking bench for arith_seq_ctrl: order vector table with a scoreboard plus hand sequences.
module tb_arith_seq_ctrl;

   localparam int unsigned CNT_W  = 5;
   localparam int          BUDGET = 80;
   localparam logic [5:0]  M_ADD  = 6'b000001;
   localparam logic [5:0]  M_SUB  = 6'b000010;
   localparam logic [5:0]  M_MUL  = 6'b000100;
   localparam logic [5:0]  M_DIV  = 6'b001000;
   localparam logic [5:0]  M_AND  = 6'b010000;
   localparam logic [5:0]  M_IO   = 6'b100000;

   logic clk, resetn;
   logic clear_a_from_pu, move_b_to_c_from_pu, move_c_to_b_from_pu, move_c_to_a_from_pu;
   logic order_add_from_op, order_sub_from_op, order_mul_from_op, order_div_from_op;
   logic order_and_from_op, order_io_from_io;
   logic [CNT_W-1:0] io_shift_count;
   logic io_digit4, mem_read_sign_from_mem, carry_out_from_au, reg_c_msb_from_au, reg_b_0_from_au;
   logic au_answer_to_op, arith_overflow_to_op, order_error_to_op, busy_to_op;
   logic do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au, do_not_a_to_au, do_not_b_to_au;
   logic do_sum_to_au, do_and_to_au, do_set_c_msb_to_au, do_left_shift_b_to_au;
   logic do_left_shift_c_to_au, do_left_shift_c_low_to_au, do_right_shift_bc_to_au;
   logic do_move_c_to_a_to_au, do_move_c_to_b_to_au, do_move_b_to_c_to_au;
   logic reg_a_sign_to_op, reg_b_sign_to_op, reg_b_sign_to_pu, mem_write_sign_to_mem, reg_c_sign_to_io;

   arith_seq_ctrl #(.WORD_W(31), .STEPS(30), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .clear_a_from_pu(clear_a_from_pu),
      .move_b_to_c_from_pu(move_b_to_c_from_pu),
      .move_c_to_b_from_pu(move_c_to_b_from_pu),
      .move_c_to_a_from_pu(move_c_to_a_from_pu),
      .order_add_from_op(order_add_from_op), .order_sub_from_op(order_sub_from_op),
      .order_mul_from_op(order_mul_from_op), .order_div_from_op(order_div_from_op),
      .order_and_from_op(order_and_from_op), .order_io_from_io(order_io_from_io),
      .io_shift_count(io_shift_count), .io_digit4(io_digit4),
      .mem_read_sign_from_mem(mem_read_sign_from_mem),
      .carry_out_from_au(carry_out_from_au), .reg_c_msb_from_au(reg_c_msb_from_au),
      .reg_b_0_from_au(reg_b_0_from_au),
      .au_answer_to_op(au_answer_to_op), .arith_overflow_to_op(arith_overflow_to_op),
      .order_error_to_op(order_error_to_op), .busy_to_op(busy_to_op),
      .do_clear_a_to_au(do_clear_a_to_au), .do_clear_b_to_au(do_clear_b_to_au),
      .do_clear_c_to_au(do_clear_c_to_au), .do_not_a_to_au(do_not_a_to_au),
      .do_not_b_to_au(do_not_b_to_au), .do_sum_to_au(do_sum_to_au), .do_and_to_au(do_and_to_au),
      .do_set_c_msb_to_au(do_set_c_msb_to_au), .do_left_shift_b_to_au(do_left_shift_b_to_au),
      .do_left_shift_c_to_au(do_left_shift_c_to_au),
      .do_left_shift_c_low_to_au(do_left_shift_c_low_to_au),
      .do_right_shift_bc_to_au(do_right_shift_bc_to_au),
      .do_move_c_to_a_to_au(do_move_c_to_a_to_au), .do_move_c_to_b_to_au(do_move_c_to_b_to_au),
      .do_move_b_to_c_to_au(do_move_b_to_c_to_au),
      .reg_a_sign_to_op(reg_a_sign_to_op), .reg_b_sign_to_op(reg_b_sign_to_op),
      .reg_b_sign_to_pu(reg_b_sign_to_pu), .mem_write_sign_to_mem(mem_write_sign_to_mem),
      .reg_c_sign_to_io(reg_c_sign_to_io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]       order;
      logic             mem_sign;
      logic             carry;
      logic [CNT_W-1:0] io_cnt;
      logic             digit;
      logic             pre_c2b;
      int ans_at; int ovf_at;
      int sums; int not_a; int not_b; int clrb; int rsh;
      int lsh_b; int lsh_c; int low; int setm; int ands; int b2c; int c2b;
      logic a_s; logic b_s; logic c_s;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   function automatic vec_t mk(input logic [5:0] order, input logic mem, input logic carry,
                               input logic [CNT_W-1:0] cnt, input logic digit, input logic pre);
      vec_t v;
      v = '{order: order, mem_sign: mem, carry: carry, io_cnt: cnt, digit: digit, pre_c2b: pre,
            ans_at: -1, ovf_at: -1, sums: 0, not_a: 0, not_b: 0, clrb: 0, rsh: 0,
            lsh_b: 0, lsh_c: 0, low: 0, setm: 0, ands: 0, b2c: 0, c2b: 0,
            a_s: 1'b0, b_s: 1'b0, c_s: 1'b0};
      return v;
   endfunction

   task automatic set_orders(input logic [5:0] m);
      order_add_from_op = m[0]; order_sub_from_op = m[1]; order_mul_from_op = m[2];
      order_div_from_op = m[3]; order_and_from_op = m[4]; order_io_from_io  = m[5];
   endtask

   // Drive one order, watch the DUT until it is idle again, then score against the queued record.
   task automatic run_txn(input vec_t v, input int idx);
      vec_t e;
      int ans_at, ovf_at, busy, errs, nans;
      int sums, not_a, not_b, clrb, rsh, lsh_b, lsh_c, low, setm, ands, b2c, c2b;
      bit done;
      string tag;
      ans_at = -1; ovf_at = -1; busy = 0; errs = 0; nans = 0; done = 0;
      sums = 0; not_a = 0; not_b = 0; clrb = 0; rsh = 0;
      lsh_b = 0; lsh_c = 0; low = 0; setm = 0; ands = 0; b2c = 0; c2b = 0;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      if (v.pre_c2b) begin
         move_c_to_b_from_pu = 1'b1;
         #1 check({tag, "_pu_c2b_fwd"}, 32'(do_move_c_to_b_to_au), 1);
         @(negedge clk);
         move_c_to_b_from_pu = 1'b0;
      end
      set_orders(v.order);
      mem_read_sign_from_mem = v.mem_sign;
      io_shift_count = v.io_cnt;
      io_digit4 = v.digit;
      carry_out_from_au = v.carry;
      sb.push_back(v);
      @(negedge clk);
      set_orders(6'b0);
      mem_read_sign_from_mem = 1'b0;
      for (int k = 1; k <= BUDGET; k++) begin
         reg_c_msb_from_au = k[1];
         reg_b_0_from_au   = k[1];
         #1;
         if (!busy_to_op) begin
            done = 1;
            break;
         end
         busy++;
         if (au_answer_to_op)      begin ans_at = k; nans++; end
         if (arith_overflow_to_op) ovf_at = k;
         if (order_error_to_op)    errs++;
         sums  += int'(do_sum_to_au);          not_a += int'(do_not_a_to_au);
         not_b += int'(do_not_b_to_au);        clrb  += int'(do_clear_b_to_au);
         rsh   += int'(do_right_shift_bc_to_au); lsh_b += int'(do_left_shift_b_to_au);
         lsh_c += int'(do_left_shift_c_to_au);   low   += int'(do_left_shift_c_low_to_au);
         setm  += int'(do_set_c_msb_to_au);    ands  += int'(do_and_to_au);
         b2c   += int'(do_move_b_to_c_to_au);  c2b   += int'(do_move_c_to_b_to_au);
         @(negedge clk);
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_timeout busy still high after %0d cycles", tag, BUDGET);
      end
      e = sb.pop_front();
      check({tag, "_answer_at"},   ans_at, e.ans_at);
      check({tag, "_answer_cnt"},  nans, (e.ans_at > 0) ? 1 : 0);
      check({tag, "_overflow_at"}, ovf_at, e.ovf_at);
      check({tag, "_busy_cycles"}, busy, (e.ans_at > 0) ? e.ans_at : e.ovf_at);
      check({tag, "_order_err"},   errs, 0);
      check({tag, "_sum"},   sums,  e.sums);   check({tag, "_not_a"}, not_a, e.not_a);
      check({tag, "_not_b"}, not_b, e.not_b);  check({tag, "_clr_b"}, clrb,  e.clrb);
      check({tag, "_rsh"},   rsh,   e.rsh);    check({tag, "_lsh_b"}, lsh_b, e.lsh_b);
      check({tag, "_lsh_c"}, lsh_c, e.lsh_c);  check({tag, "_lsh_lo"}, low,  e.low);
      check({tag, "_set_msb"}, setm, e.setm);  check({tag, "_and"},   ands,  e.ands);
      check({tag, "_b2c"},   b2c,   e.b2c);    check({tag, "_c2b"},   c2b,   e.c2b);
      check({tag, "_a_sign"}, 32'(reg_a_sign_to_op), 32'(e.a_s));
      check({tag, "_b_sign"}, 32'(reg_b_sign_to_op), 32'(e.b_s));
      check({tag, "_b_sign_pu"}, 32'(reg_b_sign_to_pu), 32'(e.b_s));
      check({tag, "_c_sign_mem"}, 32'(mem_write_sign_to_mem), 32'(e.c_s));
      check({tag, "_c_sign_io"}, 32'(reg_c_sign_to_io), 32'(e.c_s));
   endtask

   initial begin
      vec_t v;
      int nans;
      resetn = 1'b0;
      clear_a_from_pu = 0; move_b_to_c_from_pu = 0; move_c_to_b_from_pu = 0; move_c_to_a_from_pu = 0;
      set_orders(6'b0);
      io_shift_count = '0; io_digit4 = 0; mem_read_sign_from_mem = 0;
      carry_out_from_au = 0; reg_c_msb_from_au = 0; reg_b_0_from_au = 0;

      // Vector table; sign expectations follow the running a/b/c sign history from reset.
      v = mk(M_ADD, 1, 0, 0, 0, 0); v.ans_at = 2;  v.sums = 1; v.b2c = 1; v.a_s = 1; vecs.push_back(v);
      v = mk(M_SUB, 0, 0, 0, 0, 0); v.ans_at = 4;  v.not_a = 2; v.not_b = 1; v.sums = 1; v.b2c = 1;
      v.c_s = 1; vecs.push_back(v);
      v = mk(M_SUB, 1, 1, 0, 0, 0); v.ans_at = 3;  v.not_a = 1; v.sums = 1; v.b2c = 1; v.a_s = 1;
      vecs.push_back(v);
      v = mk(M_MUL, 1, 0, 0, 0, 0); v.ans_at = 62; v.clrb = 1; v.sums = 15; v.rsh = 30; v.b2c = 1;
      v.a_s = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_DIV, 0, 0, 0, 0, 0); v.ans_at = 63; v.not_a = 1; v.lsh_b = 30; v.lsh_c = 30; v.low = 30;
      v.sums = 15; v.setm = 15; v.c2b = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_AND, 1, 0, 0, 0, 1); v.ans_at = 2;  v.ands = 1; v.c2b = 1;
      v.a_s = 1; v.b_s = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_MUL, 0, 0, 0, 0, 0); v.ans_at = 62; v.clrb = 1; v.sums = 15; v.rsh = 30; v.b2c = 1;
      v.b_s = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_ADD, 1, 1, 0, 0, 0); v.ovf_at = 1; v.a_s = 1; v.b_s = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_DIV, 0, 1, 0, 0, 0); v.ovf_at = 2; v.not_a = 1; v.b_s = 1; v.c_s = 1; vecs.push_back(v);
      v = mk(M_SUB, 0, 0, 0, 0, 0); v.ans_at = 4;  v.not_a = 2; v.not_b = 1; v.sums = 1; v.b2c = 1;
      v.b_s = 1; vecs.push_back(v);
      v = mk(M_IO, 1, 0, 4, 1, 0);  v.ans_at = 5;  v.lsh_c = 4; v.low = 4; v.a_s = 1; v.b_s = 1;
      vecs.push_back(v);
      v = mk(M_IO, 0, 0, 0, 0, 0);  v.ans_at = 1;  v.b_s = 1; vecs.push_back(v);
      v = mk(M_IO, 1, 0, 3, 0, 0);  v.ans_at = 4;  v.lsh_c = 3; v.a_s = 1; v.b_s = 1; vecs.push_back(v);
      v = mk(M_ADD, 0, 0, 0, 0, 0); v.ans_at = 2;  v.sums = 1; v.b2c = 1; v.b_s = 1; v.c_s = 1;
      vecs.push_back(v);

      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      check("rst_busy", 32'(busy_to_op), 0);
      check("rst_answer", 32'(au_answer_to_op), 0);
      check("rst_overflow", 32'(arith_overflow_to_op), 0);
      check("rst_order_err", 32'(order_error_to_op), 0);
      check("rst_signs", 32'({reg_a_sign_to_op, reg_b_sign_to_op, mem_write_sign_to_mem}), 0);

      for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);

      // Mul and div together: mul wins, error flagged; busy-time orders/moves dropped; clear_a aborts.
      @(negedge clk);
      set_orders(M_MUL | M_DIV);
      mem_read_sign_from_mem = 1'b1;
      @(negedge clk);
      set_orders(6'b0);
      #1;
      check("multi_order_err", 32'(order_error_to_op), 1);
      check("multi_mul_wins", 32'(do_clear_b_to_au), 1);
      check("multi_no_div", 32'(do_not_a_to_au), 0);
      nans = 0;
      for (int k = 2; k <= 10; k++) begin
         @(negedge clk);
         order_add_from_op   = (k == 5);
         move_b_to_c_from_pu = (k == 7);
         clear_a_from_pu     = (k == 10);
         #1;
         if (au_answer_to_op) nans++;
         if (k == 2) check("err_single_pulse", 32'(order_error_to_op), 0);
         if (k == 6) check("busy_order_err", 32'(order_error_to_op), 1);
         if (k == 7) check("busy_move_blocked", 32'(do_move_b_to_c_to_au), 0);
         if (k == 8) check("busy_move_err", 32'(order_error_to_op), 1);
         if (k == 10) begin
            check("clear_a_fwd", 32'(do_clear_a_to_au), 1);
            check("clear_a_busy_before", 32'(busy_to_op), 1);
         end
      end
      check("clear_no_answer", nans, 0);
      @(negedge clk);
      clear_a_from_pu = 1'b1;
      order_add_from_op = 1'b1;
      #1;
      check("clear_idle", 32'(busy_to_op), 0);
      check("clear_a_sign", 32'(reg_a_sign_to_op), 0);
      check("clear_keeps_b", 32'(reg_b_sign_to_op), 1);
      @(negedge clk);
      clear_a_from_pu = 1'b0;
      order_add_from_op = 1'b0;
      #1;
      check("clear_drops_order", 32'(busy_to_op), 0);
      check("clear_no_err", 32'(order_error_to_op), 0);

      // pu copy in idle: a <= c.
      @(negedge clk);
      move_c_to_a_from_pu = 1'b1;
      #1 check("pu_c2a_fwd", 32'(do_move_c_to_a_to_au), 1);
      @(negedge clk);
      move_c_to_a_from_pu = 1'b0;
      #1 check("pu_c2a_sign", 32'(reg_a_sign_to_op), 1);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      order_mul_from_op = 1'b1;
      mem_read_sign_from_mem = 1'b1;
      @(negedge clk);
      order_mul_from_op = 1'b0;
      mem_read_sign_from_mem = 1'b0;
      repeat (4) @(negedge clk);
      #3 resetn = 1'b0;
      #1;
      check("areset_busy", 32'(busy_to_op), 0);
      check("areset_signs",
            32'({reg_a_sign_to_op, reg_b_sign_to_op, mem_write_sign_to_mem, reg_c_sign_to_io}), 0);
      @(negedge clk);
      resetn = 1'b1;
      v = mk(M_ADD, 0, 0, 0, 0, 0); v.ans_at = 2; v.sums = 1; v.b2c = 1;
      run_txn(v, 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
